// File: rtl/quote_engine.sv
// quote_engine: two-stage market-maker quote pipeline with per-stock throttle and show-ahead output FIFO.
// Define QUOTE_ENGINE_STATS_EN to add the o_drop_count throttle-discard counter port.
module quote_engine #(
    parameter int DATA_WIDTH   = 32,
    parameter int FP_WORD_SIZE = 64,
    parameter int NUM_STOCKS   = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int MIN_GAP      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_data_valid,
    output logic                          o_ready,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic [FP_WORD_SIZE-1:0]       i_ref_price,
    input  logic [FP_WORD_SIZE-1:0]       i_spread,
    input  logic                          i_buffer_full,
    input  logic [DATA_WIDTH-1:0]         i_best_bid,
    input  logic [DATA_WIDTH-1:0]         i_best_ask,
    output logic [DATA_WIDTH-1:0]         o_buy_price,
    output logic [DATA_WIDTH-1:0]         o_sell_price,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic                          o_data_valid,
    input  logic                          i_ready
`ifdef QUOTE_ENGINE_STATS_EN
    ,
    output logic [15:0]                   o_drop_count
`endif
);

    localparam int SW = $clog2(NUM_STOCKS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = MIN_GAP > 1 ? $clog2(MIN_GAP) : 1;
    localparam int HF = FP_WORD_SIZE / 2;
    localparam logic [GW-1:0] GAP_LOAD = MIN_GAP > 0 ? GW'(MIN_GAP - 1) : '0;

    logic [FP_WORD_SIZE-1:0] half, bid_fp, ask_fp;
    logic [FP_WORD_SIZE:0]   ask_sum;
    logic [GW-1:0]           gap [NUM_STOCKS];
    logic                    accept, keep;

    assign accept  = i_data_valid && o_ready;
    assign keep    = accept && gap[i_stock_id] == '0;
    assign half    = i_spread >> 1;
    assign ask_sum = {1'b0, i_ref_price} + {1'b0, half};
    assign bid_fp  = i_ref_price >= half ? i_ref_price - half : '0;
    assign ask_fp  = ask_sum[FP_WORD_SIZE] ? '1 : ask_sum[FP_WORD_SIZE-1:0];

    // A kept quote reloads its own counter; every other counter just runs down.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_STOCKS; i++) gap[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STOCKS; i++)
                gap[i] <= (keep && i_stock_id == SW'(i)) ? GAP_LOAD :
                          (gap[i] != '0 ? gap[i] - GW'(1) : '0);
        end
    end

    logic                  s1_valid, s1_warm, s2_valid;
    logic [SW-1:0]         s1_stock, s2_stock;
    logic [DATA_WIDTH-1:0] s1_bid, s1_ask, s1_best_bid, s1_best_ask;
    logic [DATA_WIDTH-1:0] s2_buy, s2_sell, ask_m1, bid_p1, buy_q, sell_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= keep;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            s1_stock    <= i_stock_id;
            s1_warm     <= i_buffer_full;
            s1_bid      <= DATA_WIDTH'(bid_fp >> HF);
            s1_ask      <= DATA_WIDTH'(ask_fp >> HF);
            s1_best_bid <= i_best_bid;
            s1_best_ask <= i_best_ask;
        end
        s2_stock <= s1_stock;
        s2_buy   <= buy_q;
        s2_sell  <= sell_q;
    end

    // Quotes never cross the book: buy stays below best ask, sell above best bid.
    assign ask_m1 = s1_best_ask - DATA_WIDTH'(1);
    assign bid_p1 = s1_best_bid + DATA_WIDTH'(1);
    assign buy_q  = !s1_warm ? s1_best_bid :
                    (s1_best_ask != '0 && s1_bid > ask_m1) ? ask_m1 : s1_bid;
    assign sell_q = !s1_warm ? s1_best_ask :
                    (s1_best_bid != '1 && s1_ask < bid_p1) ? bid_p1 : s1_ask;

    logic [DATA_WIDTH-1:0] fifo_buy   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_sell  [FIFO_DEPTH];
    logic [SW-1:0]         fifo_stock [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr, count;
    logic [AW+1:0]         inflight;
    logic                  pop;

    assign count        = wr_ptr - rd_ptr;
    assign o_data_valid = wr_ptr != rd_ptr;
    assign pop          = o_data_valid && i_ready;
    assign inflight     = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
    assign o_ready      = inflight < (AW+2)'(FIFO_DEPTH);
    assign o_buy_price  = o_data_valid ? fifo_buy[rd_ptr[AW-1:0]] : '0;
    assign o_sell_price = o_data_valid ? fifo_sell[rd_ptr[AW-1:0]] : '0;
    assign o_stock_id   = o_data_valid ? fifo_stock[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= s2_valid ? wr_ptr + (AW+1)'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (s2_valid) begin
            fifo_buy[wr_ptr[AW-1:0]]   <= s2_buy;
            fifo_sell[wr_ptr[AW-1:0]]  <= s2_sell;
            fifo_stock[wr_ptr[AW-1:0]] <= s2_stock;
        end
    end

`ifdef QUOTE_ENGINE_STATS_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_drop_count <= '0;
        else if (accept && !keep && o_drop_count != 16'hFFFF)
            o_drop_count <= o_drop_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_quote_engine.sv
// tb_quote_engine: directed vectors against hand-computed quotes for quote_engine.
module tb_quote_engine;

    logic        i_clk = 1'b0, i_reset_n = 1'b0, i_data_valid = 1'b0;
    logic        i_buffer_full = 1'b0, i_ready = 1'b0;
    logic        o_ready, o_data_valid;
    logic [1:0]  i_stock_id = '0, o_stock_id;
    logic [63:0] i_ref_price = '0, i_spread = '0;
    logic [31:0] i_best_bid = '0, i_best_ask = '0, o_buy_price, o_sell_price;
`ifdef QUOTE_ENGINE_STATS_EN
    logic [15:0] o_drop_count;
`endif
    int n_vec = 0, n_err = 0;

    quote_engine dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_data_valid(i_data_valid), .o_ready(o_ready),
        .i_stock_id(i_stock_id), .i_ref_price(i_ref_price), .i_spread(i_spread),
        .i_buffer_full(i_buffer_full), .i_best_bid(i_best_bid), .i_best_ask(i_best_ask),
        .o_buy_price(o_buy_price), .o_sell_price(o_sell_price), .o_stock_id(o_stock_id),
        .o_data_valid(o_data_valid), .i_ready(i_ready)
`ifdef QUOTE_ENGINE_STATS_EN
        , .o_drop_count(o_drop_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] fx(input int n);
        return 64'(n) << 32;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [63:0] r, input logic [63:0] sp,
                         input logic w, input logic [31:0] bb, input logic [31:0] ba);
        i_stock_id    = 2'(s);
        i_ref_price   = r;
        i_spread      = sp;
        i_buffer_full = w;
        i_best_bid    = bb;
        i_best_ask    = ba;
        i_data_valid  = 1'b1;
    endtask

    task automatic send(input int s, input logic [63:0] r, input logic [63:0] sp,
                        input logic w, input logic [31:0] bb, input logic [31:0] ba);
        drive(s, r, sp, w, bb, ba);
        chk("send_rdy", 64'(o_ready), 64'd1);
        tick;
        i_data_valid = 1'b0;
    endtask

    task automatic head(input string tag, input int s, input logic [31:0] b, input logic [31:0] a);
        chk({tag, "_vld"}, 64'(o_data_valid), 64'd1);
        chk({tag, "_buy"}, 64'(o_buy_price), 64'(b));
        chk({tag, "_sell"}, 64'(o_sell_price), 64'(a));
        chk({tag, "_id"}, 64'(o_stock_id), 64'(s));
    endtask

    task automatic pop;
        i_ready = 1'b1;
        tick;
        i_ready = 1'b0;
    endtask

    initial begin
        int acc;
        tick;
        tick;
        chk("rst_vld", 64'(o_data_valid), 64'd0);
        chk("rst_buy", 64'(o_buy_price), 64'd0);
        chk("rst_sell", 64'(o_sell_price), 64'd0);
        chk("rst_id", 64'(o_stock_id), 64'd0);
        chk("rst_rdy", 64'(o_ready), 64'd1);
`ifdef QUOTE_ENGINE_STATS_EN
        chk("rst_drop", 64'(o_drop_count), 64'd0);
`endif
        i_reset_n = 1'b1;
        tick;

        send(2, fx(100), fx(2), 1'b1, 32'd98, 32'd102);
        chk("lat0", 64'(o_data_valid), 64'd0);
        tick;
        chk("lat1", 64'(o_data_valid), 64'd0);
        tick;
        head("basic", 2, 32'd99, 32'd101);
        pop;
        chk("basic_empty", 64'(o_data_valid), 64'd0);

        send(3, fx(100), 64'h8000_0000, 1'b1, 32'd100, 32'd100);
        tick;
        tick;
        head("clamp", 3, 32'd99, 32'd101);
        pop;

        send(0, fx(100), fx(2), 1'b0, 32'd50, 32'd55);
        tick;
        tick;
        head("cold", 0, 32'd50, 32'd55);
        pop;

        send(1, fx(1), fx(4), 1'b1, 32'd0, 32'hFFFF_FFFF);
        tick;
        tick;
        head("uflow", 1, 32'd0, 32'd3);
        pop;

        send(2, 64'hFFFF_FFFF_0000_0000, fx(4), 1'b1, 32'd0, 32'd0);
        tick;
        tick;
        head("oflow", 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        pop;

        for (int i = 0; i < 5; i++) begin
            drive(1, fx(10 + i), 64'd0, 1'b1, 32'd0, 32'd0);
            chk("thr_rdy", 64'(o_ready), 64'd1);
            tick;
        end
        i_data_valid = 1'b0;
        tick;
        tick;
        head("thr0", 1, 32'd10, 32'd10);
        pop;
        head("thr1", 1, 32'd14, 32'd14);
        pop;
        chk("thr_empty", 64'(o_data_valid), 64'd0);
`ifdef QUOTE_ENGINE_STATS_EN
        chk("thr_drop", 64'(o_drop_count), 64'd3);
`endif

        acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive(i % 4, fx(20 + i), 64'd0, 1'b1, 32'd0, 32'd0);
            if (o_ready) acc++;
            tick;
        end
        i_data_valid = 1'b0;
        chk("bp_acc", 64'(acc), 64'd8);
        chk("bp_rdy", 64'(o_ready), 64'd0);
        tick;
        tick;
        i_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            head($sformatf("bp%0d", j), j % 4, 32'(20 + j), 32'(20 + j));
            tick;
        end
        i_ready = 1'b0;
        chk("bp_empty", 64'(o_data_valid), 64'd0);
        chk("bp_rdy_back", 64'(o_ready), 64'd1);

        for (int i = 0; i < 3; i++) begin
            drive(i, fx(40 + i), 64'd0, 1'b1, 32'd0, 32'd0);
            tick;
        end
        i_data_valid = 1'b0;
        tick;
        tick;
        chk("prerst_vld", 64'(o_data_valid), 64'd1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("arst_vld", 64'(o_data_valid), 64'd0);
        chk("arst_buy", 64'(o_buy_price), 64'd0);
        chk("arst_rdy", 64'(o_ready), 64'd1);
`ifdef QUOTE_ENGINE_STATS_EN
        chk("arst_drop", 64'(o_drop_count), 64'd0);
`endif
        #2 i_reset_n = 1'b1;
        tick;
        send(3, fx(60), 64'd0, 1'b1, 32'd0, 32'd0);
        chk("plat0", 64'(o_data_valid), 64'd0);
        tick;
        chk("plat1", 64'(o_data_valid), 64'd0);
        tick;
        head("post_rst", 3, 32'd60, 32'd60);
        pop;
        chk("post_empty", 64'(o_data_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
